// File: rtl/a10_fp32_normalize_pipe.sv
// Fixed-point accumulator to IEEE-754 fp32 converter.
// Four pipeline stages share one advance enable: capture, LZC wait, normalise, then round and pack.
// Rounding is round-to-nearest-even. Results that underflow flush to zero; overflow gives infinity.

// Leading-zero counter with a registered output.
// An all-zero input produces WIDTH.
module a10_leading_zero_counter #(
  parameter int WIDTH = 48,
  parameter int OUT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [OUT_W-1:0] dout
);

  logic [OUT_W-1:0] cnt_d;
  logic [OUT_W-1:0] cnt_q;

  // Scan from the LSB upward so the highest set bit is the one that sets the count.
  // NOTE: give every always_comb output a default before any conditional; otherwise a latch is inferred.
  always_comb begin
    cnt_d = OUT_W'(WIDTH);
    for (int i = 0; i < WIDTH; i++) begin
      if (din[i]) cnt_d = OUT_W'(WIDTH - 1 - i);
    end
  end

  // Register the count every cycle. The caller keeps din aligned with its own stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign dout = cnt_q;

endmodule

module a10_fp32_normalize_pipe #(
  parameter int SIZE  = 48,
  parameter int EXP_W = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [SIZE-1:0]   in_acc,
  input  logic [EXP_W-1:0]  in_exp,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_data
);

  localparam int LZC_W = $clog2(SIZE + 1);
  localparam int EW    = EXP_W + 2;

  logic en;

  // Stage 1: capture
  logic [SIZE-1:0]  mag1_d, mag1_q;
  logic             v1_q, sign1_q;
  logic [EXP_W-1:0] exp1_q;
  // Stage 2: wait for the LZC result
  logic [SIZE-1:0]  mag2_q;
  logic             v2_q, sign2_q;
  logic [EXP_W-1:0] exp2_q;
  logic [SIZE-1:0]  lzc_din;
  logic [LZC_W-1:0] lz;
  // Stage 3: normalise
  logic [SIZE-1:0]      norm3_d, norm3_q;
  logic signed [EW-1:0] e3_d, e3_q;
  logic                 v3_q, sign3_q, zero3_q;
  // Stage 4: round and pack
  logic [22:0]          frac, frac_r;
  logic                 guard, sticky, round_up, carry;
  logic signed [EW-1:0] e_r;
  logic [31:0]          data_d, data_q;
  logic                 v4_q;

  // Every stage advances together unless a valid result is waiting for the consumer.
  assign en        = ~v4_q | out_ready;
  assign in_ready  = en;
  assign out_valid = v4_q;
  assign out_data  = data_q;

  // Magnitude. The most negative input maps to 2^(SIZE-1), which still fits unsigned.
  assign mag1_d = in_acc[SIZE-1] ? (~in_acc + 1'b1) : in_acc;

  // Stage 1 register: capture a beat, or a bubble when in_valid is low.
  // NOTE: clear the data registers along with the valid bits so reset leaves no X in the pipeline.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q    <= 1'b0;
      sign1_q <= 1'b0;
      mag1_q  <= '0;
      exp1_q  <= '0;
    end else if (en) begin
      // NOTE: use non-blocking assignments for state so every stage samples the values from before the edge.
      v1_q    <= in_valid;
      sign1_q <= in_acc[SIZE-1];
      mag1_q  <= mag1_d;
      exp1_q  <= in_exp;
    end
  end

  // Stage 2 register: hold the beat while the LZC works on it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v2_q    <= 1'b0;
      sign2_q <= 1'b0;
      mag2_q  <= '0;
      exp2_q  <= '0;
    end else if (en) begin
      v2_q    <= v1_q;
      sign2_q <= sign1_q;
      mag2_q  <= mag1_q;
      exp2_q  <= exp1_q;
    end
  end

  // The LZC input is the next value of mag2, so its output matches stage 2 even across stalls.
  assign lzc_din = en ? mag1_q : mag2_q;

  a10_leading_zero_counter #(.WIDTH(SIZE), .OUT_W(LZC_W)) u_lzc (
    .clk  (clk),
    .rst  (rst),
    .din  (lzc_din),
    .dout (lz)
  );

  assign norm3_d = mag2_q << lz;
  assign e3_d    = $signed({2'b00, exp2_q}) - $signed({{(EW-LZC_W){1'b0}}, lz});

  // Stage 3 register: the normalised mantissa and the exponent adjusted by the shift.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v3_q    <= 1'b0;
      sign3_q <= 1'b0;
      zero3_q <= 1'b0;
      norm3_q <= '0;
      e3_q    <= '0;
    end else if (en) begin
      v3_q    <= v2_q;
      sign3_q <= sign2_q;
      zero3_q <= (lz == LZC_W'(SIZE));
      norm3_q <= norm3_d;
      e3_q    <= e3_d;
    end
  end

  assign frac  = norm3_q[SIZE-2 -: 23];
  assign guard = norm3_q[SIZE-25];

  // Sticky covers every bit below the guard bit. When SIZE is 25 there are no such bits.
  if (SIZE > 25) begin : g_sticky
    assign sticky = |norm3_q[SIZE-26:0];
  end else begin : g_no_sticky
    assign sticky = 1'b0;
  end

  assign round_up        = guard & (sticky | frac[0]);
  assign {carry, frac_r} = {1'b0, frac} + 24'(round_up);
  assign e_r             = e3_q + $signed({{(EW-1){1'b0}}, carry});

  // Pack the result. Zero has the highest priority, then underflow, then overflow.
  // A clear hidden bit can only come from a zero magnitude, so it is treated as zero as well.
  always_comb begin
    data_d = {sign3_q, e_r[7:0], frac_r};
    if (zero3_q || !norm3_q[SIZE-1]) data_d = 32'h0;
    else if (e_r <= 0)               data_d = {sign3_q, 31'h0};
    else if (e_r >= 255)             data_d = {sign3_q, 8'hFF, 23'h0};
  end

  // Stage 4 register: this register drives the output port directly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v4_q   <= 1'b0;
      data_q <= 32'h0;
    end else if (en) begin
      v4_q   <= v3_q;
      data_q <= data_d;
    end
  end

endmodule
